// File: rtl/tbus_sram_responder_pkg.sv
// Shared encodings for the Trinity Bus SRAM responder.
// Op-type codes, field widths and FSM states.
package tbus_sram_responder_pkg;

  localparam int TBUS_OPTYPE_W = 2;
  localparam int RESULT_W      = 64;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_OP_READ  = 2'b00;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_OP_WRITE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } tbus_state_e;

endpackage

// File: rtl/tbus_sram_array.sv
// Single-port 64-bit SRAM with bit-masked write.
// Read result is registered and zeroed for non-read accesses.
module tbus_sram_array
  import tbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [RESULT_W-1:0]   wdata,
  input  logic [RESULT_W-1:0]   wmask,
  output logic [RESULT_W-1:0]   rdata
);

  logic [RESULT_W-1:0] mem [2**DEPTH_LOG2];

  // Array contents are deliberately outside reset.
  always_ff @(posedge clock) begin
    if (ce && we)
      mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge clock) begin
    if (reset)
      rdata <= '0;
    else if (ce)
      rdata <= re ? mem[addr] : '0;
  end

endmodule

// File: rtl/tbus_sram_responder.sv
// Trinity Bus target: one request in flight, masked-write SRAM,
// completion pulse a fixed LATENCY after the accept edge.
module tbus_sram_responder
  import tbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tbus_index_valid,
  output logic                     tbus_index_ready,
  input  logic [63:0]              tbus_index,
  input  logic [RESULT_W-1:0]      tbus_write_data,
  input  logic [RESULT_W-1:0]      tbus_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
  output logic [RESULT_W-1:0]      tbus_read_data,
  output logic                     tbus_operation_done,
  output logic                     resp_error
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("tbus_sram_responder: LATENCY must be 1..15");
    end
  endgenerate

  tbus_state_e state, state_nx;

  logic [3:0]               cnt;
  logic [63:0]              req_index;
  logic [RESULT_W-1:0]      req_wdata;
  logic [RESULT_W-1:0]      req_wmask;
  logic [TBUS_OPTYPE_W-1:0] req_op;
  logic [63:0]              offset;
  logic                     accept;
  logic                     access;
  logic                     in_range;
  logic                     op_ok;
  logic                     bad;
  logic                     unused_ok;

  assign tbus_index_ready    = (state == ST_IDLE);
  assign tbus_operation_done = (state == ST_RESP);

  assign accept = tbus_index_valid && tbus_index_ready;
  assign access = (state == ST_BUSY) && (cnt == 4'd0);

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset    = req_index - BASE_ADDR;
  assign in_range  = (offset[63:DEPTH_LOG2+3] == '0);
  assign op_ok     = (req_op == TBUS_OP_READ) || (req_op == TBUS_OP_WRITE);
  assign bad       = !in_range || !op_ok;
  assign unused_ok = ^offset[2:0];

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_BUSY;
      ST_BUSY: if (cnt == 4'd0) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept)
        cnt <= 4'(LATENCY - 1);
      else if (state == ST_BUSY && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (access && bad)
        resp_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      req_index <= tbus_index;
      req_wdata <= tbus_write_data;
      req_wmask <= tbus_write_mask;
      req_op    <= tbus_operation_type;
    end
  end

  tbus_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .ce   (access),
    .we   (!bad && req_op == TBUS_OP_WRITE),
    .re   (!bad && req_op == TBUS_OP_READ),
    .addr (offset[DEPTH_LOG2+2:3]),
    .wdata(req_wdata),
    .wmask(req_wmask),
    .rdata(tbus_read_data)
  );

endmodule

// File: tb/tb_tbus_sram_responder.sv
// Randomized bench for tbus_sram_responder against a word-level
// memory model with sticky error tracking.
module tb_tbus_sram_responder;

  localparam int          DL   = 12;
  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [63:0] index;
  logic [63:0] wdata;
  logic [63:0] wmask;
  logic [1:0]  op;
  logic [63:0] rdata;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [longint unsigned];
  logic        err_m;

  always #5 clock = ~clock;

  tbus_sram_responder #(
    .DEPTH_LOG2(DL),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .tbus_index_valid   (valid),
    .tbus_index_ready   (ready),
    .tbus_index         (index),
    .tbus_write_data    (wdata),
    .tbus_write_mask    (wmask),
    .tbus_operation_type(op),
    .tbus_read_data     (rdata),
    .tbus_operation_done(done),
    .resp_error         (err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_op(input logic [1:0] o,
                                           input logic [63:0] idx,
                                           input logic [63:0] d,
                                           input logic [63:0] m);
    logic [63:0] off;
    longint unsigned w;
    off = idx - BASE;
    if (o > 2'd1 || off >= (64'd1 << (DL + 3))) begin
      err_m = 1'b1;
      return 64'd0;
    end
    w = longint'(off >> 3);
    if (o == 2'd1) begin
      model[w] = (model[w] & ~m) | (d & m);
      return 64'd0;
    end
    return model[w];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input string tag, input logic [1:0] o,
                       input logic [63:0] idx, input logic [63:0] d,
                       input logic [63:0] m);
    logic [63:0] exp;
    int n;
    int lat;
    exp   = model_op(o, idx, d, m);
    op    = o;
    index = idx;
    wdata = d;
    wmask = m;
    valid = 1'b1;
    n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    valid = 1'b0;
    index = $urandom();
    wdata = {$urandom(), $urandom()};
    wmask = {$urandom(), $urandom()};
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_rd"}, rdata, exp);
    check({tag, "_err"}, 64'(err), 64'(err_m));
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    err_m = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    int last_acc;
    int n_acc;
    int n_done;
    valid = 1'b0;
    index = '0;
    wdata = '0;
    wmask = '0;
    op    = 2'd0;
    err_m = 1'b0;

    do_reset();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Preload the low 16 words with full-mask writes.
    issue("pre0", 2'd1, BASE, 64'h1122334455667788, '1);
    issue("pre1", 2'd1, BASE + 64'd8, 64'd0, '1);
    for (int w = 2; w < 16; w++)
      issue("pre", 2'd1, BASE + 64'(w * 8), {$urandom(), $urandom()}, '1);

    issue("rd_base", 2'd0, BASE, 64'd0, 64'd0);
    check("rd_base_val", rdata, 64'h1122334455667788);
    issue("wr_mask", 2'd1, BASE + 64'd8, '1, 64'h0000_0000_FFFF_0000);
    issue("rd_mask", 2'd0, BASE + 64'd8, 64'd0, 64'd0);
    check("rd_mask_val", rdata, 64'h0000_0000_FFFF_0000);

    for (int i = 0; i < 40; i++) begin
      a = BASE + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        issue("rnd_rd", 2'd0, a, 64'd0, 64'd0);
      else
        issue("rnd_wr", 2'd1, a, {$urandom(), $urandom()},
              ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom(), $urandom()});
    end

    issue("oor_lo", 2'd0, 64'h7FFF_FFF8, 64'd0, 64'd0);
    issue("oor_hi", 2'd0, BASE + (64'd1 << (DL + 3)), 64'd0, 64'd0);
    issue("oor_wr", 2'd1, BASE + (64'd1 << (DL + 3)), '1, '1);
    issue("rsv_op", 2'd2, BASE + 64'd16, '1, '1);
    issue("rsv_op3", 2'd3, BASE + 64'd24, '1, '1);
    issue("chk_w2", 2'd0, BASE + 64'd16, 64'd0, 64'd0);
    issue("chk_w3", 2'd0, BASE + 64'd24, 64'd0, 64'd0);
    check("err_sticky", 64'(err), 64'd1);
    do_reset();
    check("err_clear", 64'(err), 64'd0);

    // Stream with valid held high: fixed spacing, one done per accept.
    op = 2'd0;
    index = BASE;
    valid = 1'b1;
    last_acc = -1;
    n_acc = 0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        n_done++;
        check("strm_rd", rdata, model[0]);
      end
      if (ready) begin
        if (last_acc >= 0)
          check("strm_gap", 64'(c - last_acc), 64'(LAT + 2));
        last_acc = c;
        n_acc++;
      end
      tick();
    end
    valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done) n_done++;
      tick();
    end
    check("strm_count", 64'(n_done), 64'(n_acc));

    // Reset in the first BUSY cycle drops the pending write.
    op    = 2'd1;
    index = BASE + 64'd32;
    wdata = ~model[4];
    wmask = '1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("rb_busy", 64'(ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) n_done++;
      tick();
    end
    check("rb_nodone", 64'(n_done), 64'd0);
    check("rb_ready", 64'(ready), 64'd1);
    issue("rb_keep", 2'd0, BASE + 64'd32, 64'd0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
